// File: rtl/mem_tracker_if.sv
// ============================================================================
// mem_tracker_if
// ----------------------------------------------------------------------------
// Scan / flush bus between the scanner subsystem and the occupancy tracker.
// master: the scanner side driving scan pulses, flush requests, link ready.
// slave : the tracker reporting occupancy, status and flush grants.
// Optional overflow-counter bus present only with MEMTRACK_OVF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_tracker_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  logic [NCH-1:0]   scan;
  logic [NCH-1:0]   flush_req;
  logic             link_ready;
  logic [NCH*W-1:0] mem_used;
  logic [NCH-1:0]   full;
  logic [NCH-1:0]   empty;
  logic [NCH-1:0]   almost_full;
  logic [NCH-1:0]   flush_grant;
  logic [W-1:0]     flush_amt;
`ifdef MEMTRACK_OVF_CNT_EN
  logic [NCH*8-1:0] ovf_cnt;

  modport master (
    output scan, flush_req, link_ready,
    input  mem_used, full, empty, almost_full, flush_grant, flush_amt, ovf_cnt
  );
  modport slave (
    input  scan, flush_req, link_ready,
    output mem_used, full, empty, almost_full, flush_grant, flush_amt, ovf_cnt
  );
`else
  modport master (
    output scan, flush_req, link_ready,
    input  mem_used, full, empty, almost_full, flush_grant, flush_amt
  );
  modport slave (
    input  scan, flush_req, link_ready,
    output mem_used, full, empty, almost_full, flush_grant, flush_amt
  );
`endif
endinterface

`default_nettype wire

// File: rtl/mem_tracker.sv
// ============================================================================
// mem_tracker
// ----------------------------------------------------------------------------
// Multi-channel scan-memory occupancy tracker. One saturating counter per
// channel, +1 per scan cycle, drained STEP units at a time through a single
// shared flush link arbitrated round-robin. Full / empty / almost-full are
// decoded straight from the registered occupancy.
// Optional feature macro: MEMTRACK_OVF_CNT_EN (per-channel 8-bit sticky count
// of scans rejected because the channel was full).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_tracker #(
  parameter int NCH       = 4,
  parameter int W         = 8,
  parameter int CAP       = 100,
  parameter int STEP      = 3,
  parameter int AF_THRESH = 90
) (
  input  logic          clk,
  input  logic          reset,
  mem_tracker_if.slave  bus_if
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [W-1:0]  c_cap     = W'(CAP);
  localparam logic [W-1:0]  c_step    = W'(STEP);
  localparam logic [W-1:0]  c_af      = W'(AF_THRESH);
  localparam logic [PW-1:0] c_rr_init = PW'(NCH - 1);

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  logic [W-1:0]   used_q [NCH];
  logic [W-1:0]   used_d [NCH];
  logic [W-1:0]   w_dec  [NCH];
  logic [NCH-1:0] w_elig;

  arb_state_t     arb_state_q;
  logic [PW-1:0]  rr_ptr_q;
  logic [NCH-1:0] grant_q;
  logic [W-1:0]   amt_q;

  logic           w_gnt_vld;
  logic [PW-1:0]  w_gnt_idx;
  logic [PW-1:0]  w_cand;
  logic [W-1:0]   w_amt;

  // Round-robin pick: first eligible channel after the last one served.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_cand = PW'((int'(rr_ptr_q) + k) % NCH);
      if (!w_gnt_vld && bus_if.link_ready && w_elig[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    w_amt = w_gnt_vld ? w_dec[w_gnt_idx] : '0;
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic w_inc;

      // A scan is only accepted on the pre-update value, so a same-cycle
      // flush on a full channel never lets the scan in.
      assign w_inc     = bus_if.scan[i] & (used_q[i] < c_cap);
      assign w_elig[i] = bus_if.flush_req[i] & (used_q[i] != '0);
      assign w_dec[i]  = (w_gnt_vld && (w_gnt_idx == PW'(i)))
                       ? ((used_q[i] < c_step) ? used_q[i] : c_step)
                       : '0;
      assign used_d[i] = used_q[i] + W'(w_inc) - w_dec[i];

      assign bus_if.mem_used[i*W +: W] = used_q[i];
      assign bus_if.full[i]            = (used_q[i] == c_cap);
      assign bus_if.empty[i]           = (used_q[i] == '0);
      assign bus_if.almost_full[i]     = (used_q[i] >= c_af);

`ifdef MEMTRACK_OVF_CNT_EN
      logic [7:0] ovf_q;

      // Sticky, saturating count of scans rejected on a full channel.
      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q <= '0;
        end else if (bus_if.scan[i] && (used_q[i] == c_cap) && (ovf_q != 8'hFF)) begin
          ovf_q <= ovf_q + 8'd1;
        end
      end

      assign bus_if.ovf_cnt[i*8 +: 8] = ovf_q;
`endif
    end
  endgenerate

  // Occupancy registers for all channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) used_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) used_q[i] <= used_d[i];
    end
  end

  // Arbiter state, rotation pointer and registered grant/amount outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_state_q <= ARB_IDLE;
      rr_ptr_q    <= c_rr_init;
      grant_q     <= '0;
      amt_q       <= '0;
    end else if (w_gnt_vld) begin
      arb_state_q <= ARB_GRANT;
      rr_ptr_q    <= w_gnt_idx;
      grant_q     <= NCH'(1) << w_gnt_idx;
      amt_q       <= w_amt;
    end else begin
      arb_state_q <= ARB_IDLE;
      grant_q     <= '0;
      amt_q       <= '0;
    end
  end

  assign bus_if.flush_grant = (arb_state_q == ARB_GRANT) ? grant_q : '0;
  assign bus_if.flush_amt   = (arb_state_q == ARB_GRANT) ? amt_q   : '0;

endmodule

`default_nettype wire
